// File: rtl/shift_reg_serial_rx.sv
// Serial receiver: rebuilds MSB-first DATA_W-bit words (optional even-parity trailer) onto a valid/ready port.
// Word appears one cycle after its last bit; a completed word that cannot be accepted is dropped and flagged.
module shift_reg_serial_rx #(
  parameter int DATA_W    = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              shift_reg_clk,
  input  logic              shift_reg_rst_n,
  input  logic              shift_rx_sin_vld,
  input  logic              shift_rx_sin,
  input  logic              shift_rx_sof,
  output logic [DATA_W-1:0] shift_rx_dout,
  output logic              shift_rx_dout_vld,
  input  logic              shift_rx_dout_rdy,
  output logic              shift_rx_par_err,
  output logic              shift_rx_overrun,
  input  logic              shift_rx_ovr_clr,
  output logic              shift_rx_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic              commit;
  logic              commit_perr;
  logic              accept;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] first_bit;

  assign shifted   = {shreg_q[DATA_W-2:0], shift_rx_sin};
  assign first_bit = {{(DATA_W-1){1'b0}}, shift_rx_sin};
  assign accept    = !vld_q || shift_rx_dout_rdy;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    commit_perr = 1'b0;
    word        = shifted;

    if (shift_rx_sin_vld) begin
      // sof always (re)starts a frame, whatever state we are in
      if (shift_rx_sof) begin
        shreg_d = first_bit;
        cnt_d   = CNT_W'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              if (PARITY_EN) begin
                state_d = PARITY;
              end else begin
                commit  = 1'b1;
                word    = shifted;
                cnt_d   = '0;
                state_d = IDLE;
              end
            end
          end
          PARITY: begin
            commit      = 1'b1;
            word        = shreg_q;
            commit_perr = (^shreg_q) ^ shift_rx_sin;
            cnt_d       = '0;
            state_d     = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    ovr_d  = ovr_q;
    busy_d = (state_d != IDLE);

    if (vld_q && shift_rx_dout_rdy) vld_d = 1'b0;
    if (shift_rx_ovr_clr) ovr_d = 1'b0;

    // a drop sets overrun after the clear so that set wins
    if (commit) begin
      if (accept) begin
        dout_d = word;
        vld_d  = 1'b1;
        perr_d = PARITY_EN ? commit_perr : 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge shift_reg_clk) begin
    if (!shift_reg_rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign shift_rx_dout     = dout_q;
  assign shift_rx_dout_vld = vld_q;
  assign shift_rx_par_err  = perr_q;
  assign shift_rx_overrun  = ovr_q;
  assign shift_rx_busy     = busy_q;

endmodule

// File: tb/tb_shift_reg_serial_rx.sv
// Directed bench for shift_reg_serial_rx: a table of per-cycle vectors for the plain receiver,
// plus a hand-written sequence for the parity-enabled variant.
module tb_shift_reg_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n, sin_vld, sin, sof, rdy, clr;
  logic [3:0] n_dout, p_dout;
  logic       n_vld, n_perr, n_ovr, n_busy;
  logic       p_vld, p_perr, p_ovr, p_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_reg_serial_rx #(.DATA_W(4), .PARITY_EN(1'b0)) u_np (
    .shift_reg_clk(clk), .shift_reg_rst_n(rst_n),
    .shift_rx_sin_vld(sin_vld), .shift_rx_sin(sin), .shift_rx_sof(sof),
    .shift_rx_dout(n_dout), .shift_rx_dout_vld(n_vld), .shift_rx_dout_rdy(rdy),
    .shift_rx_par_err(n_perr), .shift_rx_overrun(n_ovr), .shift_rx_ovr_clr(clr),
    .shift_rx_busy(n_busy)
  );

  shift_reg_serial_rx #(.DATA_W(4), .PARITY_EN(1'b1)) u_p (
    .shift_reg_clk(clk), .shift_reg_rst_n(rst_n),
    .shift_rx_sin_vld(sin_vld), .shift_rx_sin(sin), .shift_rx_sof(sof),
    .shift_rx_dout(p_dout), .shift_rx_dout_vld(p_vld), .shift_rx_dout_rdy(rdy),
    .shift_rx_par_err(p_perr), .shift_rx_overrun(p_ovr), .shift_rx_ovr_clr(clr),
    .shift_rx_busy(p_busy)
  );

  typedef struct {
    int         tag;
    logic       rst_n, vld, sin, sof, rdy, clr;
    logic       e_vld;
    logic [3:0] e_dout;
    logic       e_ovr, e_busy;
  } vec_t;

  vec_t vq[$];

  // bit cycle: sin_vld=1
  function automatic void b(int tag, logic s, logic f, logic r, logic c,
                            logic ev, logic [3:0] ed, logic eo, logic eb);
    vec_t v;
    v = '{tag, 1'b1, 1'b1, s, f, r, c, ev, ed, eo, eb};
    vq.push_back(v);
  endfunction

  // gap cycle: sin_vld=0
  function automatic void g(int tag, logic r, logic c,
                            logic ev, logic [3:0] ed, logic eo, logic eb);
    vec_t v;
    v = '{tag, 1'b1, 1'b0, 1'b0, 1'b0, r, c, ev, ed, eo, eb};
    vq.push_back(v);
  endfunction

  function automatic void rst_row(int tag);
    vec_t v;
    v = '{tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vq.push_back(v);
  endfunction

  task automatic drive(logic r_n, logic v, logic s, logic f, logic r, logic c);
    rst_n = r_n; sin_vld = v; sin = s; sof = f; rdy = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_np(vec_t v, int idx);
    logic ok;
    ok = (n_vld === v.e_vld) && (n_ovr === v.e_ovr) && (n_busy === v.e_busy) && (n_perr === 1'b0);
    if (v.e_vld || !v.rst_n) ok = ok && (n_dout === v.e_dout);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL vec%0d tag%0d: got vld=%b dout=%b ovr=%b busy=%b perr=%b, want vld=%b dout=%b ovr=%b busy=%b perr=0",
               idx, v.tag, n_vld, n_dout, n_ovr, n_busy, n_perr, v.e_vld, v.e_dout, v.e_ovr, v.e_busy);
    end
  endtask

  task automatic check_p(string name, logic ev, logic [3:0] ed, logic ep, logic eb);
    logic ok;
    ok = (p_vld === ev) && (p_busy === eb) && (p_ovr === 1'b0);
    if (ev) ok = ok && (p_dout === ed) && (p_perr === ep);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got vld=%b dout=%b perr=%b busy=%b ovr=%b, want vld=%b dout=%b perr=%b busy=%b ovr=0",
               name, p_vld, p_dout, p_perr, p_busy, p_ovr, ev, ed, ep, eb);
    end
  endtask

  initial begin
    rst_n = 1'b0; sin_vld = 1'b0; sin = 1'b0; sof = 1'b0; rdy = 1'b1; clr = 1'b0;

    rst_row(0);
    // 1: back-to-back frame 1011, consumer ready
    b(1, 1, 1, 1, 0, 0, 4'h0, 0, 1);
    b(1, 0, 0, 1, 0, 0, 4'h0, 0, 1);
    b(1, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    b(1, 1, 0, 1, 0, 1, 4'b1011, 0, 0);
    g(1, 1, 0, 0, 4'h0, 0, 0);
    // bits without sof in IDLE are ignored
    b(7, 1, 0, 1, 0, 0, 4'h0, 0, 0);
    // 2: same frame with 2-cycle gaps
    b(2, 1, 1, 1, 0, 0, 4'h0, 0, 1);
    g(2, 1, 0, 0, 4'h0, 0, 1); g(2, 1, 0, 0, 4'h0, 0, 1);
    b(2, 0, 0, 1, 0, 0, 4'h0, 0, 1);
    g(2, 1, 0, 0, 4'h0, 0, 1); g(2, 1, 0, 0, 4'h0, 0, 1);
    b(2, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    g(2, 1, 0, 0, 4'h0, 0, 1); g(2, 1, 0, 0, 4'h0, 0, 1);
    b(2, 1, 0, 1, 0, 1, 4'b1011, 0, 0);
    g(2, 1, 0, 0, 4'h0, 0, 0);
    // 3: rdy=0, 0110 held, 1001 dropped, clear, then transfer
    b(3, 0, 1, 0, 0, 0, 4'h0, 0, 1);
    b(3, 1, 0, 0, 0, 0, 4'h0, 0, 1);
    b(3, 1, 0, 0, 0, 0, 4'h0, 0, 1);
    b(3, 0, 0, 0, 0, 1, 4'b0110, 0, 0);
    b(3, 1, 1, 0, 0, 1, 4'b0110, 0, 1);
    b(3, 0, 0, 0, 0, 1, 4'b0110, 0, 1);
    b(3, 0, 0, 0, 0, 1, 4'b0110, 0, 1);
    b(3, 1, 0, 0, 0, 1, 4'b0110, 1, 0);
    g(3, 0, 1, 1, 4'b0110, 0, 0);
    g(3, 1, 0, 0, 4'h0, 0, 0);
    // overrun set wins over a same-cycle clear
    b(8, 1, 1, 0, 0, 0, 4'h0, 0, 1);
    b(8, 1, 0, 0, 0, 0, 4'h0, 0, 1);
    b(8, 1, 0, 0, 0, 0, 4'h0, 0, 1);
    b(8, 1, 0, 0, 0, 1, 4'b1111, 0, 0);
    b(8, 0, 1, 0, 0, 1, 4'b1111, 0, 1);
    b(8, 0, 0, 0, 0, 1, 4'b1111, 0, 1);
    b(8, 0, 0, 0, 0, 1, 4'b1111, 0, 1);
    b(8, 0, 0, 0, 1, 1, 4'b1111, 1, 0);
    g(8, 0, 1, 1, 4'b1111, 0, 0);
    g(8, 1, 0, 0, 4'h0, 0, 0);
    // transfer and commit in the same cycle: no bubble, no overrun
    b(9, 1, 1, 0, 0, 0, 4'h0, 0, 1);
    b(9, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    b(9, 1, 0, 0, 0, 0, 4'h0, 0, 1);
    b(9, 0, 0, 0, 0, 1, 4'b1010, 0, 0);
    b(9, 0, 1, 0, 0, 1, 4'b1010, 0, 1);
    b(9, 0, 0, 0, 0, 1, 4'b1010, 0, 1);
    b(9, 1, 0, 0, 0, 1, 4'b1010, 0, 1);
    b(9, 1, 0, 1, 0, 1, 4'b0011, 0, 0);
    g(9, 1, 0, 0, 4'h0, 0, 0);
    // 5: aborted frame 1,1 then restart 0101
    b(5, 1, 1, 1, 0, 0, 4'h0, 0, 1);
    b(5, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    b(5, 0, 1, 1, 0, 0, 4'h0, 0, 1);
    b(5, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    b(5, 0, 0, 1, 0, 0, 4'h0, 0, 1);
    b(5, 1, 0, 1, 0, 1, 4'b0101, 0, 0);
    g(5, 1, 0, 0, 4'h0, 0, 0);
    // 6: reset after 3 bits, then 1100
    b(6, 1, 1, 1, 0, 0, 4'h0, 0, 1);
    b(6, 0, 0, 1, 0, 0, 4'h0, 0, 1);
    b(6, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    rst_row(6);
    b(6, 1, 1, 1, 0, 0, 4'h0, 0, 1);
    b(6, 1, 0, 1, 0, 0, 4'h0, 0, 1);
    b(6, 0, 0, 1, 0, 0, 4'h0, 0, 1);
    b(6, 0, 0, 1, 0, 1, 4'b1100, 0, 0);
    g(6, 1, 0, 0, 4'h0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst_n, vq[i].vld, vq[i].sin, vq[i].sof, vq[i].rdy, vq[i].clr);
      check_np(vq[i], i);
    end

    // 4: parity variant, 1011 (odd weight) with good and bad trailer
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_p("p_reset", 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_p("p_wait_parity", 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_p("p_good", 1'b1, 4'b1011, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_p("p_vld_drop", 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_p("p_bad", 1'b1, 4'b1011, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_p("p_idle", 1'b0, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
